// File: rtl/mimc_feistel_engine_if.sv
// ---------------------------------------------------------------------------
// mimc_feistel_engine_if
// Start/done handshake and data bus of the MiMC Feistel engine.
//   master : requester; drives start, decrypt, in_left, in_right, key and
//            observes ready, busy, done, out_left, out_right
//   slave  : the engine; mirror image of master
// N_BITS must match the engine the interface is bound to.
// ---------------------------------------------------------------------------
interface mimc_feistel_engine_if #(
    parameter int N_BITS = 254
);
    logic              start;
    logic              decrypt;
    logic [N_BITS-1:0] in_left;
    logic [N_BITS-1:0] in_right;
    logic [N_BITS-1:0] key;
    logic              ready;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] out_left;
    logic [N_BITS-1:0] out_right;

    modport master (
        output start, decrypt, in_left, in_right, key,
        input  ready, busy, done, out_left, out_right
    );

    modport slave (
        input  start, decrypt, in_left, in_right, key,
        output ready, busy, done, out_left, out_right
    );
endinterface

// File: rtl/mimc_feistel_engine.sv
// ---------------------------------------------------------------------------
// mimc_feistel_engine
// Iterative MiMC Feistel block cipher over GF(P) with a built-in bit-serial
// modular multiplier. With key = 0 it is the MiMC permutation.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (aborts any operation)
//   bus    : mimc_feistel_engine_if.slave
//            start/decrypt/in_left/in_right/key sampled when start && ready
//            ready = idle, busy = operation in flight, done = 1-cycle pulse
//            out_left/out_right hold the result until the next accepted start
//
// Parameters:
//   N_BITS          field element width
//   P               field modulus, P < 2^N_BITS
//   ROUNDS          Feistel round count (>= 1)
//   EXPONENT        S-box exponent: 3, 5 or 7
//   ROUND_CONSTANTS packed round-constant table; constant i lives in
//                   bits [i*N_BITS +: N_BITS]
//
// Round i: t = (xL + key + c[i])^EXPONENT mod P, then
//   non-final round: (xL, xR) <= (xR op t, xL)
//   final round    : (xL, xR) <= (xL, xR op t)
// where op is +t for encrypt and -t for decrypt (constants walked in reverse).
// Latency start->done: ROUNDS*(2 + M*(N_BITS+1)) + 1, M = 2/3/4 for e=3/5/7.
// ---------------------------------------------------------------------------
module mimc_feistel_engine #(
    parameter int                       N_BITS          = 254,
    parameter logic [N_BITS-1:0]        P               = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                       ROUNDS          = 220,
    parameter int                       EXPONENT        = 5,
    parameter logic [ROUNDS*N_BITS-1:0] ROUND_CONSTANTS = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mimc_feistel_engine_if.slave  bus
);

    // Number of chained multiplies for the S-box: x^2,x^3 / x^2,x^4,x^5 /
    // x^2,x^4,x^6,x^7.
    localparam int MUL_COUNT = (EXPONENT == 3) ? 2 : (EXPONENT == 5) ? 3 : 4;
    localparam int IDX_W     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int BIT_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [1:0]       LAST_MUL = 2'(MUL_COUNT - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_MUL,
        S_UPDATE,
        S_FINISH
    } state_t;

    // Both operands are < P, so one conditional subtract at N_BITS+1 bits
    // fully reduces the sum.
    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[N_BITS-1:0];
    endfunction

    function automatic logic [N_BITS-1:0] mod_sub(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [N_BITS:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, a} + {1'b0, P} - {1'b0, b};
        end
        return d[N_BITS-1:0];
    endfunction

    state_t            state;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic [N_BITS-1:0] out_l_q;
    logic [N_BITS-1:0] out_r_q;

    logic [N_BITS-1:0] x_l;
    logic [N_BITS-1:0] x_r;
    logic [N_BITS-1:0] key_r;
    logic              dec_r;
    logic [IDX_W-1:0]  round_idx;

    logic [N_BITS-1:0] base;      // S-box input x
    logic [N_BITS-1:0] sq;        // x^2, reused by the e=7 chain
    logic [N_BITS-1:0] mul_a;     // multiplicand added on a set bit
    logic [N_BITS-1:0] mul_b;     // multiplier, consumed MSB first
    logic [N_BITS-1:0] mul_acc;   // running product; holds the result after a multiply
    logic [BIT_W-1:0]  bit_cnt;
    logic [1:0]        mul_k;     // position in the multiply chain
    logic              mul_setup;

    logic [N_BITS-1:0] round_const;
    logic [N_BITS-1:0] acc_dbl;
    logic [N_BITS-1:0] acc_step;
    logic [N_BITS-1:0] x_new;
    logic              is_final;

    // NOTE: the constant table is a parameter (a ROM folded into logic), so
    // there is no memory here that would need a reset or a load sequence.
    assign round_const = ROUND_CONSTANTS[int'(round_idx)*N_BITS +: N_BITS];

    // One double-and-add step: acc = 2*acc (+ a if the current bit is set).
    assign acc_dbl  = mod_add(mul_acc, mul_acc);
    assign acc_step = mul_b[N_BITS-1] ? mod_add(acc_dbl, mul_a) : acc_dbl;

    // mul_acc holds t = base^EXPONENT when UPDATE is reached.
    assign x_new    = dec_r ? mod_sub(x_r, mul_acc) : mod_add(x_r, mul_acc);

    // The last round executed is c[ROUNDS-1] for encrypt and c[0] for decrypt;
    // stopping there keeps the index inside 0..ROUNDS-1 with no wrap.
    assign is_final = dec_r ? (round_idx == '0) : (round_idx == LAST_IDX);

    // NOTE: every register in this block uses non-blocking assignment so all
    // next-state values are computed from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            x_l       <= '0;
            x_r       <= '0;
            key_r     <= '0;
            dec_r     <= 1'b0;
            round_idx <= '0;
            base      <= '0;
            sq        <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_acc   <= '0;
            bit_cnt   <= '0;
            mul_k     <= '0;
            mul_setup <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x_l       <= bus.in_left;
                        x_r       <= bus.in_right;
                        key_r     <= bus.key;
                        dec_r     <= bus.decrypt;
                        round_idx <= bus.decrypt ? LAST_IDX : '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= S_ADD;
                    end
                end

                S_ADD: begin
                    base      <= mod_add(mod_add(x_l, key_r), round_const);
                    mul_k     <= '0;
                    mul_setup <= 1'b1;
                    state     <= S_MUL;
                end

                S_MUL: begin
                    if (mul_setup) begin
                        // Operand pick for chain step k; mul_acc still holds
                        // the previous product during this cycle.
                        mul_setup <= 1'b0;
                        bit_cnt   <= TOP_BIT;
                        mul_acc   <= '0;
                        if (mul_k == 2'd1) begin
                            sq <= mul_acc;
                        end
                        if (mul_k == 2'd0) begin
                            mul_a <= base;
                            mul_b <= base;
                        end else if (mul_k == LAST_MUL) begin
                            mul_a <= mul_acc;
                            mul_b <= base;
                        end else if (mul_k == 2'd1) begin
                            mul_a <= mul_acc;
                            mul_b <= mul_acc;
                        end else begin
                            mul_a <= mul_acc;
                            mul_b <= sq;
                        end
                    end else begin
                        mul_acc <= acc_step;
                        mul_b   <= mul_b << 1;
                        if (bit_cnt == '0) begin
                            if (mul_k == LAST_MUL) begin
                                state <= S_UPDATE;
                            end else begin
                                mul_k     <= mul_k + 2'd1;
                                mul_setup <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end

                S_UPDATE: begin
                    if (is_final) begin
                        // The result is registered on entry to FINISH so the
                        // outputs are already valid while done is high.
                        x_r     <= x_new;
                        out_l_q <= x_l;
                        out_r_q <= x_new;
                        done_q  <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        x_l       <= x_new;
                        x_r       <= x_l;
                        round_idx <= dec_r ? round_idx - 1'b1 : round_idx + 1'b1;
                        state     <= S_ADD;
                    end
                end

                S_FINISH: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_left  = out_l_q;
    assign bus.out_right = out_r_q;

endmodule

// File: tb/tb_mimc_feistel_engine.sv
// ---------------------------------------------------------------------------
// tb_mimc_feistel_engine
// Four engine instances over small fields:
//   a: N=8,  P=251,   ROUNDS=1, e=3, c={0}
//   b: N=8,  P=251,   ROUNDS=2, e=3, c={0,1}
//   c: N=8,  P=251,   ROUNDS=6, e=7, fixed constants
//   d: N=16, P=65521, ROUNDS=5, e=5, fixed constants
// Known-answer vectors, handshake corner cases on instance b, then random
// encrypt/decrypt round trips on c and d against a plain-arithmetic MiMC model.
// ---------------------------------------------------------------------------
module tb_mimc_feistel_engine;

    localparam logic [47:0] C2 = {8'd5, 8'd128, 8'd99, 8'd3, 8'd250, 8'd17};
    localparam logic [79:0] C3 = {16'd1, 16'd40000, 16'd7, 16'd65520, 16'd12345};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mimc_feistel_engine_if #(.N_BITS(8))  if_a ();
    mimc_feistel_engine_if #(.N_BITS(8))  if_b ();
    mimc_feistel_engine_if #(.N_BITS(8))  if_c ();
    mimc_feistel_engine_if #(.N_BITS(16)) if_d ();

    mimc_feistel_engine #(
        .N_BITS(8), .P(8'd251), .ROUNDS(1), .EXPONENT(3), .ROUND_CONSTANTS(8'd0)
    ) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

    mimc_feistel_engine #(
        .N_BITS(8), .P(8'd251), .ROUNDS(2), .EXPONENT(3), .ROUND_CONSTANTS({8'd1, 8'd0})
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    mimc_feistel_engine #(
        .N_BITS(8), .P(8'd251), .ROUNDS(6), .EXPONENT(7), .ROUND_CONSTANTS(C2)
    ) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    mimc_feistel_engine #(
        .N_BITS(16), .P(16'd65521), .ROUNDS(5), .EXPONENT(5), .ROUND_CONSTANTS(C3)
    ) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit st, input bit dec,
                         input logic [15:0] l, input logic [15:0] r, input logic [15:0] k);
        case (sel)
            0: begin if_a.start = st; if_a.decrypt = dec; if_a.in_left = l[7:0]; if_a.in_right = r[7:0]; if_a.key = k[7:0]; end
            1: begin if_b.start = st; if_b.decrypt = dec; if_b.in_left = l[7:0]; if_b.in_right = r[7:0]; if_b.key = k[7:0]; end
            2: begin if_c.start = st; if_c.decrypt = dec; if_c.in_left = l[7:0]; if_c.in_right = r[7:0]; if_c.key = k[7:0]; end
            default: begin if_d.start = st; if_d.decrypt = dec; if_d.in_left = l; if_d.in_right = r; if_d.key = k; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if_a.done;
            1: return if_b.done;
            2: return if_c.done;
            default: return if_d.done;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return if_a.ready;
            1: return if_b.ready;
            2: return if_c.ready;
            default: return if_d.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if_a.busy;
            1: return if_b.busy;
            2: return if_c.busy;
            default: return if_d.busy;
        endcase
    endfunction

    function automatic logic [15:0] get_out_l(input int sel);
        case (sel)
            0: return {8'd0, if_a.out_left};
            1: return {8'd0, if_b.out_left};
            2: return {8'd0, if_c.out_left};
            default: return if_d.out_left;
        endcase
    endfunction

    function automatic logic [15:0] get_out_r(input int sel);
        case (sel)
            0: return {8'd0, if_a.out_right};
            1: return {8'd0, if_b.out_right};
            2: return {8'd0, if_c.out_right};
            default: return if_d.out_right;
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic longint cfg_p(input int sel);
        return (sel == 3) ? 65521 : 251;
    endfunction

    function automatic int cfg_rounds(input int sel);
        case (sel)
            0: return 1;
            1: return 2;
            2: return 6;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_exp(input int sel);
        case (sel)
            2: return 7;
            3: return 5;
            default: return 3;
        endcase
    endfunction

    function automatic longint cfg_const(input int sel, input int idx);
        case (sel)
            0: return 0;
            1: return (idx == 0) ? 0 : 1;
            2: return longint'(C2[idx*8 +: 8]);
            default: return longint'(C3[idx*16 +: 16]);
        endcase
    endfunction

    function automatic int expected_latency(input int sel);
        int nb;
        int m;
        nb = (sel == 3) ? 16 : 8;
        m  = (cfg_exp(sel) == 3) ? 2 : (cfg_exp(sel) == 5) ? 3 : 4;
        return cfg_rounds(sel) * (2 + m * (nb + 1)) + 1;
    endfunction

    function automatic void mimc_model(input int sel, input bit dec,
                                       input longint l_in, input longint r_in, input longint k,
                                       output longint l_out, output longint r_out);
        longint p, l, r, base, t, tmp;
        int nr, idx;
        p  = cfg_p(sel);
        nr = cfg_rounds(sel);
        l  = l_in;
        r  = r_in;
        for (int n = 0; n < nr; n++) begin
            idx  = dec ? nr - 1 - n : n;
            base = (l + k + cfg_const(sel, idx)) % p;
            t    = 1;
            for (int j = 0; j < cfg_exp(sel); j++) t = (t * base) % p;
            if (dec) t = (p - t) % p;
            if (n == nr - 1) begin
                r = (r + t) % p;
            end else begin
                tmp = l;
                l   = (r + t) % p;
                r   = tmp;
            end
        end
        l_out = l;
        r_out = r;
    endfunction

    // Starts one operation (caller sits #1 after a posedge with the engine idle)
    // and returns in the done cycle. lat counts posedges from the accepting one.
    task automatic run_op(input int sel, input bit dec,
                          input logic [15:0] l, input logic [15:0] r, input logic [15:0] k,
                          output logic [15:0] ol, output logic [15:0] orr, output int lat);
        drive(sel, 1'b1, dec, l, r, k);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~dec, ~l, ~r, ~k);
        lat = 1;
        while (!get_done(sel) && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        ol  = get_out_l(sel);
        orr = get_out_r(sel);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          sel;
        bit          dec;
        logic [15:0] l, r, k;
        logic [15:0] exp_l, exp_r;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0] ol, orr, l, r, k, el, er, dl, dr;
        longint      ml, mr, p;
        int          lat;

        n_checks = 0;
        n_errors = 0;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);

        vecs[0] = '{sel: 0, dec: 1'b0, l: 16'd2,  r: 16'd5,   k: 16'd0, exp_l: 16'd2,  exp_r: 16'd13,  exp_lat: 21};
        vecs[1] = '{sel: 0, dec: 1'b1, l: 16'd2,  r: 16'd13,  k: 16'd0, exp_l: 16'd2,  exp_r: 16'd5,   exp_lat: 21};
        vecs[2] = '{sel: 1, dec: 1'b0, l: 16'd3,  r: 16'd4,   k: 16'd1, exp_l: 16'd68, exp_r: 16'd137, exp_lat: 41};
        vecs[3] = '{sel: 1, dec: 1'b1, l: 16'd68, r: 16'd137, k: 16'd1, exp_l: 16'd3,  exp_r: 16'd4,   exp_lat: 41};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("reset ready[%0d]", s), longint'(get_ready(s)), 1);
            check($sformatf("reset busy[%0d]", s),  longint'(get_busy(s)),  0);
            check($sformatf("reset done[%0d]", s),  longint'(get_done(s)),  0);
            check($sformatf("reset out_l[%0d]", s), longint'(get_out_l(s)), 0);
            check($sformatf("reset out_r[%0d]", s), longint'(get_out_r(s)), 0);
        end
        #3 rst_n = 1'b1;
        next_cycle();

        // ---- known-answer vectors ----
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].dec, vecs[i].l, vecs[i].r, vecs[i].k, ol, orr, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d out_l", i), longint'(ol), longint'(vecs[i].exp_l));
            check($sformatf("vec%0d out_r", i), longint'(orr), longint'(vecs[i].exp_r));
            next_cycle();
        end

        // ---- start pulsed mid-run is ignored ----
        drive(1, 1'b1, 1'b0, 16'd3, 16'd4, 16'd1);
        next_cycle();
        lat = 1;
        while (!get_done(1) && lat < 2000) begin
            if (lat == 10) drive(1, 1'b1, 1'b1, 16'd9, 16'd9, 16'd5);
            else           drive(1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            next_cycle();
            lat++;
        end
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        check("midstart latency", lat, 41);
        check("midstart out_l", longint'(get_out_l(1)), 68);
        check("midstart out_r", longint'(get_out_r(1)), 137);
        repeat (5) next_cycle();
        check("hold out_l", longint'(get_out_l(1)), 68);
        check("hold out_r", longint'(get_out_r(1)), 137);
        check("hold done", longint'(get_done(1)), 0);
        check("hold ready", longint'(get_ready(1)), 1);

        // ---- start in the done cycle: ignored, taken one cycle later ----
        run_op(1, 1'b0, 16'd3, 16'd4, 16'd1, ol, orr, lat);
        check("done-cycle ready", longint'(get_ready(1)), 0);
        drive(1, 1'b1, 1'b1, 16'd68, 16'd137, 16'd1);
        next_cycle();
        check("after-done ready", longint'(get_ready(1)), 1);
        check("after-done busy", longint'(get_busy(1)), 0);
        next_cycle();
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        check("late-accept busy", longint'(get_busy(1)), 1);
        lat = 1;
        while (!get_done(1) && lat < 2000) begin
            next_cycle();
            lat++;
        end
        check("late-accept latency", lat, 41);
        check("late-accept out_l", longint'(get_out_l(1)), 3);
        check("late-accept out_r", longint'(get_out_r(1)), 4);
        next_cycle();

        // ---- asynchronous reset mid-run ----
        run_op(1, 1'b0, 16'd3, 16'd4, 16'd1, ol, orr, lat);
        next_cycle();
        drive(1, 1'b1, 1'b0, 16'd10, 16'd20, 16'd30);
        next_cycle();
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        repeat (19) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("abort ready", longint'(get_ready(1)), 1);
        check("abort busy", longint'(get_busy(1)), 0);
        check("abort done", longint'(get_done(1)), 0);
        check("abort out_l", longint'(get_out_l(1)), 0);
        check("abort out_r", longint'(get_out_r(1)), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        run_op(1, 1'b1, 16'd68, 16'd137, 16'd1, ol, orr, lat);
        check("post-reset latency", lat, 41);
        check("post-reset out_l", longint'(ol), 3);
        check("post-reset out_r", longint'(orr), 4);
        next_cycle();

        // ---- random round trips against the model ----
        for (int s = 2; s < 4; s++) begin
            p = cfg_p(s);
            for (int n = 0; n < 12; n++) begin
                if (n == 0) begin
                    l = 16'(p - 1); r = 16'(p - 1); k = 16'(p - 1);
                end else begin
                    l = 16'($urandom_range(0, 32'(p - 1)));
                    r = 16'($urandom_range(0, 32'(p - 1)));
                    k = 16'($urandom_range(0, 32'(p - 1)));
                end
                mimc_model(s, 1'b0, longint'(l), longint'(r), longint'(k), ml, mr);
                el = 16'(ml);
                er = 16'(mr);
                run_op(s, 1'b0, l, r, k, ol, orr, lat);
                check($sformatf("rnd%0d.%0d enc latency", s, n), lat, expected_latency(s));
                check($sformatf("rnd%0d.%0d enc out_l", s, n), longint'(ol), longint'(el));
                check($sformatf("rnd%0d.%0d enc out_r", s, n), longint'(orr), longint'(er));
                next_cycle();
                run_op(s, 1'b1, el, er, k, dl, dr, lat);
                check($sformatf("rnd%0d.%0d dec out_l", s, n), longint'(dl), longint'(l));
                check($sformatf("rnd%0d.%0d dec out_r", s, n), longint'(dr), longint'(r));
                next_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
